// File: rtl/start_token_fifo.sv
// Shift-register FIFO with show-ahead output: the oldest token is always on if_dout.
// Occupancy flags are registered and updated on the same edge as the counter.
module start_token_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_empty_n;
  logic                  r_full_n;

  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH:0]   w_cnt_nxt;
  logic [ADDR_WIDTH:0]   w_cnt_dec;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  // Handshake: a push is accepted when if_write & if_write_ce & if_full_n, a pop
  // when if_read & if_read_ce & if_empty_n; requests outside those cycles are dropped.
  assign w_push = if_write & if_write_ce & r_full_n;
  assign w_pop  = if_read  & if_read_ce  & r_empty_n;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop)
      w_cnt_nxt = r_count + CNT_ONE;
    else if (w_pop && !w_push)
      w_cnt_nxt = r_count - CNT_ONE;
  end

  assign w_cnt_dec  = w_cnt_nxt - CNT_ONE;
  assign w_addr_nxt = (w_cnt_nxt == '0) ? '0 : w_cnt_dec[ADDR_WIDTH-1:0];

  // Storage is not reset; the reset term only keeps it from shifting on a reset edge.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[0] <= if_din;
      for (int i = DEPTH-1; i > 0; i--)
        r_mem[i] <= r_mem[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_addr    <= '0;
      r_empty_n <= 1'b0;
      r_full_n  <= 1'b1;
    end else begin
      r_count   <= w_cnt_nxt;
      r_addr    <= w_addr_nxt;
      r_empty_n <= (w_cnt_nxt != '0);
      r_full_n  <= (w_cnt_nxt != CNT_DEPTH);
    end
  end

  assign if_dout           = r_mem[r_addr];
  assign if_empty_n        = r_empty_n;
  assign if_full_n         = r_full_n;
  assign if_num_data_valid = r_count;

endmodule

// File: tb/tb_start_token_fifo.sv
// Directed bench for start_token_fifo with DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4.
module tb_start_token_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       if_write_ce = 1'b1;
  logic       if_write = 1'b0;
  logic [7:0] if_din = 8'h00;
  logic       if_full_n;
  logic       if_read_ce = 1'b1;
  logic       if_read = 1'b0;
  logic [7:0] if_dout;
  logic       if_empty_n;
  logic [2:0] if_num_data_valid;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  start_token_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .if_write_ce(if_write_ce),
    .if_write(if_write),
    .if_din(if_din),
    .if_full_n(if_full_n),
    .if_read_ce(if_read_ce),
    .if_read(if_read),
    .if_dout(if_dout),
    .if_empty_n(if_empty_n),
    .if_num_data_valid(if_num_data_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    if_write = w;
    if_din   = d;
    if_read  = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++; if (if_num_data_valid !== 3'd0) begin errors++; $display("FAIL rst_async_num got %0d want 0", if_num_data_valid); end
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL rst_async_empty_n got %b want 0", if_empty_n); end
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL rst_async_full_n got %b want 1", if_full_n); end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_num_data_valid !== 3'd0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold cyc %0d got num=%0d empty_n=%b full_n=%b want 0/0/1", i, if_num_data_valid, if_empty_n, if_full_n);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] v [4];
    v = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, v[i], 1'b0);
      step();
      checks++; if (if_num_data_valid !== 3'(i+1)) begin errors++; $display("FAIL fill_num %0d got %0d want %0d", i, if_num_data_valid, i+1); end
      checks++; if (if_dout !== 8'h11) begin errors++; $display("FAIL fill_dout %0d got %h want 11", i, if_dout); end
      checks++; if (if_full_n !== (i < 3)) begin errors++; $display("FAIL fill_full_n %0d got %b want %b", i, if_full_n, (i < 3)); end
    end
    drive(1'b1, 8'h55, 1'b0);
    step();
    checks++; if (if_num_data_valid !== 3'd4) begin errors++; $display("FAIL overflow_num got %0d want 4", if_num_data_valid); end
    checks++; if (if_full_n !== 1'b0) begin errors++; $display("FAIL overflow_full_n got %b want 0", if_full_n); end
    checks++; if (if_dout !== 8'h11) begin errors++; $display("FAIL overflow_dout got %h want 11", if_dout); end
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp;
      exp = exp_q.pop_front();
      checks++; if (if_dout !== exp) begin errors++; $display("FAIL drain_dout %0d got %h want %h", i, if_dout, exp); end
      drive(1'b0, 8'h00, 1'b1);
      step();
      checks++; if (if_num_data_valid !== 3'(3-i)) begin errors++; $display("FAIL drain_num %0d got %0d want %0d", i, if_num_data_valid, 3-i); end
    end
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL drained_empty_n got %b want 0", if_empty_n); end
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL drained_full_n got %b want 1", if_full_n); end
  endtask

  task automatic test_simul_push_pop();
    drive(1'b1, 8'hA1, 1'b0); step();
    drive(1'b1, 8'hA2, 1'b0); step();
    checks++; if (if_num_data_valid !== 3'd2 || if_dout !== 8'hA1) begin errors++; $display("FAIL simul_pre got num=%0d dout=%h want 2/a1", if_num_data_valid, if_dout); end
    drive(1'b1, 8'hA3, 1'b1); step();
    checks++; if (if_num_data_valid !== 3'd2) begin errors++; $display("FAIL simul_num got %0d want 2", if_num_data_valid); end
    checks++; if (if_dout !== 8'hA2) begin errors++; $display("FAIL simul_dout got %h want a2", if_dout); end
    drive(1'b0, 8'h00, 1'b1); step();
    checks++; if (if_num_data_valid !== 3'd1 || if_dout !== 8'hA3) begin errors++; $display("FAIL simul_next got num=%0d dout=%h want 1/a3", if_num_data_valid, if_dout); end
    step();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (if_num_data_valid !== 3'd0 || if_empty_n !== 1'b0) begin errors++; $display("FAIL simul_empty got num=%0d empty_n=%b want 0/0", if_num_data_valid, if_empty_n); end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 8'h5A, 1'b1); step();
    checks++; if (if_num_data_valid !== 3'd1) begin errors++; $display("FAIL empty_rw_num got %0d want 1", if_num_data_valid); end
    checks++; if (if_dout !== 8'h5A || if_empty_n !== 1'b1) begin errors++; $display("FAIL empty_rw_dout got dout=%h empty_n=%b want 5a/1", if_dout, if_empty_n); end
    drive(1'b0, 8'h00, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (if_num_data_valid !== 3'd0) begin errors++; $display("FAIL empty_rw_drain got %0d want 0", if_num_data_valid); end
  endtask

  task automatic test_full_rw();
    logic [7:0] v [4];
    v = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, v[i], 1'b0); step();
    end
    checks++; if (if_full_n !== 1'b0) begin errors++; $display("FAIL full_rw_pre got full_n=%b want 0", if_full_n); end
    drive(1'b1, 8'hC0, 1'b1); step();
    checks++; if (if_num_data_valid !== 3'd3) begin errors++; $display("FAIL full_rw_num got %0d want 3", if_num_data_valid); end
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL full_rw_full_n got %b want 1", if_full_n); end
    checks++; if (if_dout !== 8'hB2) begin errors++; $display("FAIL full_rw_dout got %h want b2", if_dout); end
    drive(1'b0, 8'h00, 1'b1); step();
    checks++; if (if_dout !== 8'hB3) begin errors++; $display("FAIL full_rw_b3 got %h want b3", if_dout); end
    step();
    checks++; if (if_dout !== 8'hB4) begin errors++; $display("FAIL full_rw_b4 got %h want b4", if_dout); end
    step();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (if_empty_n !== 1'b0 || if_num_data_valid !== 3'd0) begin errors++; $display("FAIL full_rw_empty got empty_n=%b num=%0d want 0/0", if_empty_n, if_num_data_valid); end
  endtask

  task automatic test_ce_reset();
    drive(1'b1, 8'hD1, 1'b0); step();
    drive(1'b1, 8'hD2, 1'b0); step();
    drive(1'b1, 8'hD3, 1'b0); step();
    if_write_ce = 1'b0; if_read_ce = 1'b0;
    drive(1'b1, 8'hE1, 1'b1); step();
    checks++; if (if_num_data_valid !== 3'd3 || if_dout !== 8'hD1) begin errors++; $display("FAIL ce_both_low got num=%0d dout=%h want 3/d1", if_num_data_valid, if_dout); end
    if_write_ce = 1'b0; if_read_ce = 1'b1;
    drive(1'b1, 8'hE2, 1'b0); step();
    checks++; if (if_num_data_valid !== 3'd3) begin errors++; $display("FAIL ce_write_low got num=%0d want 3", if_num_data_valid); end
    if_write_ce = 1'b1; if_read_ce = 1'b0;
    drive(1'b0, 8'h00, 1'b1); step();
    checks++; if (if_num_data_valid !== 3'd3 || if_dout !== 8'hD1) begin errors++; $display("FAIL ce_read_low got num=%0d dout=%h want 3/d1", if_num_data_valid, if_dout); end
    if_write_ce = 1'b1; if_read_ce = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    #3 reset = 1'b1;
    #1;
    checks++; if (if_num_data_valid !== 3'd0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin errors++; $display("FAIL mid_reset got num=%0d empty_n=%b full_n=%b want 0/0/1", if_num_data_valid, if_empty_n, if_full_n); end
    drive(1'b1, 8'hEE, 1'b0); step();
    checks++; if (if_num_data_valid !== 3'd0) begin errors++; $display("FAIL reset_edge_push got num=%0d want 0", if_num_data_valid); end
    drive(1'b0, 8'h00, 1'b0);
    #2 reset = 1'b0;
    step();
    checks++; if (if_num_data_valid !== 3'd0 || if_empty_n !== 1'b0) begin errors++; $display("FAIL post_reset_idle got num=%0d empty_n=%b want 0/0", if_num_data_valid, if_empty_n); end
    drive(1'b1, 8'h77, 1'b0); step();
    checks++; if (if_num_data_valid !== 3'd1 || if_dout !== 8'h77) begin errors++; $display("FAIL post_reset_push got num=%0d dout=%h want 1/77", if_num_data_valid, if_dout); end
    drive(1'b0, 8'h00, 1'b1); step();
    checks++; if (if_num_data_valid !== 3'd0 || if_empty_n !== 1'b0) begin errors++; $display("FAIL post_reset_pop got num=%0d empty_n=%b want 0/0", if_num_data_valid, if_empty_n); end
    step();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (if_num_data_valid !== 3'd0 || if_full_n !== 1'b1) begin errors++; $display("FAIL post_reset_underflow got num=%0d full_n=%b want 0/1", if_num_data_valid, if_full_n); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simul_push_pop();
    test_empty_rw();
    test_full_rw();
    test_ce_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/start_token_fifo.md
START_TOKEN_FIFO -- requirements
Module: start_token_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, width of each token.
REQ-002 SHALL have parameter ADDR_WIDTH, default 1, storage index width; DEPTH <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 2, token capacity; DEPTH >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port if_write_ce  input  1  write-side clock enable.
REQ-007 SHALL have port if_write  input  1  producer push request.
REQ-008 SHALL have port if_din  input  DATA_WIDTH  token pushed.
REQ-009 SHALL have port if_full_n  output  1  high when occupancy < DEPTH.
REQ-010 SHALL have port if_read_ce  input  1  read-side clock enable.
REQ-011 SHALL have port if_read  input  1  consumer pop request.
REQ-012 SHALL have port if_dout  output  DATA_WIDTH  oldest stored token (show-ahead).
REQ-013 SHALL have port if_empty_n  output  1  high when occupancy > 0.
REQ-014 SHALL have port if_num_data_valid  output  ADDR_WIDTH+1  current occupancy.

Function
REQ-015 Push SHALL occur in a cycle iff if_write & if_write_ce & if_full_n.
REQ-016 Pop SHALL occur in a cycle iff if_read & if_read_ce & if_empty_n.
REQ-017 Storage SHALL be a shift register of DEPTH entries: on push, entry[0] <= if_din and entry[i+1] <= entry[i] for all i; no shift without push.
REQ-018 Read index addr SHALL equal occupancy-1 when occupancy > 0, else 0; if_dout SHALL be entry[addr] combinationally.
REQ-019 Occupancy counter SHALL update: push only +1; pop only -1; both or neither unchanged.
REQ-020 if_full_n, if_empty_n, if_num_data_valid SHALL be registered, updated in the same edge as the counter, and reflect the new occupancy on the next cycle.
REQ-021 Push-to-visible latency SHALL be 1 cycle: token pushed into an empty FIFO appears on if_dout with if_empty_n=1 in the next cycle.
REQ-022 Pop SHALL expose the next-oldest token on if_dout in the following cycle.
REQ-023 Simultaneous push and pop with 0 < occupancy < DEPTH SHALL shift storage, keep addr and occupancy unchanged, and present the next-oldest token.
REQ-024 When empty, an asserted if_read SHALL be ignored; a simultaneous push SHALL proceed alone.
REQ-025 When full, an asserted if_write SHALL be ignored, storage unchanged; a simultaneous pop SHALL proceed alone.
REQ-026 if_write_ce=0 or if_read_ce=0 SHALL suppress the respective operation regardless of request.
REQ-027 if_dout value while if_empty_n=0 SHALL be unspecified and not checked.
REQ-028 Occupancy SHALL never exceed DEPTH nor go below 0.

Reset
REQ-029 Asserting reset SHALL immediately, without clock, set occupancy=0, addr=0, if_empty_n=0, if_full_n=1, if_num_data_valid=0.
REQ-030 Storage entries SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored tokens; first push after deassertion behaves as into an empty FIFO.
REQ-032 No push or pop SHALL occur on an edge where reset is high.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4)
REQ-033 Reset then idle -> if_empty_n=0, if_full_n=1, if_num_data_valid=0 held.
REQ-034 Push 0x11,0x22,0x33,0x44 on consecutive cycles -> if_full_n=0 after 4th, num_data_valid=4; extra push 0x55 ignored; pops return 0x11,0x22,0x33,0x44 then if_empty_n=0.
REQ-035 With 2 tokens (0xA1,0xA2), push 0xA3 and pop same cycle -> num_data_valid stays 2, if_dout=0xA2 next cycle, then 0xA3.
REQ-036 Empty FIFO, if_read=1 and if_write=1 (din 0x5A) same cycle -> next cycle num_data_valid=1, if_dout=0x5A; no underflow.
REQ-037 Full FIFO, if_write=1 and if_read=1 -> only pop; num_data_valid=3, if_full_n=1 next cycle.
REQ-038 Push 3 tokens, assert reset between edges with if_write_ce=0/if_read_ce=0 toggling -> outputs reset asynchronously; CE low blocks all operations; post-reset push 0x77 is the only token popped.
